mlbmp_mem_arb: RTL
==================

// Module: mlbmp_mem_arb
// PURPOSE
//  Single-port screen-RAM arbiter for the monochrome bitmap path. Shares one
//  synchronous 8-bit RAM between the video fetch port and a CPU port. The
//  video fetch port supplies byte addresses from the pixel/address mapper.
//  Video reads have absolute priority and a fixed latency. CPU writes are
//  buffered in a FIFO; CPU reads are ordered behind all buffered writes.
// PARAMETERS
//  AW          16  RAM byte-address width
//  FIFO_DEPTH  4   CPU write FIFO entries (power of two, >=2)
// PORTS
//  clk            in   1   system/pixel clock; all logic on rising edge
//  rst_n          in   1   synchronous reset, active-low
//  vid_req        in   1   video byte fetch request (1-cycle pulse or level)
//  vid_addr       in   AW  video fetch address
//  vid_valid      out  1   vid_data valid (1-cycle pulse)
//  vid_data       out  8   fetched byte
//  cpu_wr_valid   in   1   CPU write offered
//  cpu_wr_ready   out  1   FIFO not full
//  cpu_wr_addr    in   AW  write address
//  cpu_wr_data    in   8   write data
//  cpu_rd_valid   in   1   CPU read offered
//  cpu_rd_ready   out  1   no CPU read outstanding
//  cpu_rd_addr    in   AW  read address
//  cpu_rd_done    out  1   cpu_rd_data valid (1-cycle pulse)
//  cpu_rd_data    out  8   read byte
//  mem_addr       out  AW  RAM address
//  mem_we         out  1   RAM write strobe
//  mem_re         out  1   RAM read strobe
//  mem_wdata      out  8   RAM write data
//  mem_rdata      in   8   RAM read data; valid the cycle after mem_re
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): FIFO emptied, read FSM->R_IDLE, pipelines
//    cleared. vid_valid=0, cpu_rd_done=0, vid_data=0, cpu_rd_data=0,
//    cpu_wr_ready=1, cpu_rd_ready=1. A read or write in flight is dropped.
//    mem_we=0 and mem_re=0 while rst_n=0.
//  - Exactly one RAM op per cycle. mem_* are combinational from this cycle's
//    grant. Idle cycles: mem_we=mem_re=0 and mem_addr=0.
//  - Grant priority each cycle:
//    (1) vid_req;
//    (2) CPU read in R_ISSUE;
//    (3) FIFO head write (FIFO not empty).
//  - Video: vid_req in cycle T -> mem_re=1 with mem_addr=vid_addr in T.
//    vid_valid=1 with vid_data=mem_rdata in T+2 (registered).
//    Latency is always 2 and independent of CPU load.
//  - Back-to-back vid_req is legal; every cycle it holds, it starves the CPU.
//  - Write handshake: a write is accepted on an edge with
//    cpu_wr_valid & cpu_wr_ready. The entry is visible at the FIFO head the
//    next cycle. Earliest mem_we is at T+1 for an accept at T.
//  - On the same edge, a push on a full FIFO is impossible (ready=0).
//    Simultaneous push+pop keeps the count unchanged.
//  - cpu_wr_ready = (count < FIFO_DEPTH), evaluated on the registered count.
//  - Write to RAM: mem_we=1, mem_addr/mem_wdata from the FIFO head. The pop
//    happens on the same edge.
//  - Read FSM:
//    R_IDLE:   accept on cpu_rd_valid & cpu_rd_ready. Latch addr; go to
//              R_DRAIN.
//    R_DRAIN:  wait until the FIFO is empty. Writes accepted before the read
//              complete first. Then go to R_ISSUE.
//    R_ISSUE:  go to R_DATA in the cycle the grant is won. If vid_req holds,
//              stay.
//    R_DATA:   mem_rdata is captured into cpu_rd_data. cpu_rd_done pulses
//              next cycle; then back to R_IDLE.
//  - cpu_rd_ready = (state==R_IDLE).
//  - While a read is outstanding, new writes are still accepted into the
//    FIFO. They are held (not drained) from R_ISSUE until R_DATA completes.
//  - Video ordering: a video read in the same cycle as a pending write sees
//    the old RAM contents. There is no bypass.
//  - FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. The
//    count is log2(FIFO_DEPTH)+1 bits.
// TESTING
//  1. Reset: hold rst_n=0 for 3 clk.
//     -> all outputs at their reset values; cpu_wr_ready=1.
//     Pulse vid_req with addr 0x0102 at T. -> vid_valid at T+2 with RAM[0x0102].
//  2. Fill: cpu_wr_valid held for 5 writes (0x10..0x14), with vid_req held
//     high. -> ready drops after 4 accepts and no mem_we occurs. Release
//     vid_req -> 4 writes issued in order on 4 consecutive cycles.
//  3. Ordering: write 0xA5 to 0x0040, then read 0x0040 the next cycle.
//     -> cpu_rd_done returns 0xA5, never the stale byte.
//  4. Video priority: vid_req at 1 per 16 clk during a continuous CPU write
//     stream. -> every vid_valid comes exactly 2 clk after its vid_req.
//     All CPU writes land in RAM, checked by a scoreboard.
//  5. Reset mid-op: assert rst_n=0 while in R_DRAIN with 2 FIFO entries.
//     -> no mem_we after reset, no cpu_rd_done, and cpu_rd_ready=1 after
//     release.

Source files
------------

// File: rtl/mlbmp_mem_arb.sv
// mlbmp_mem_arb: single-port screen-RAM arbiter sharing one 8-bit RAM between video fetch and CPU
// Ports:
//   clk_i, rst_ni                    clock, synchronous active-low reset
//   vid_req_i, vid_addr_i            video byte fetch request and address
//   vid_valid_o, vid_data_o          fetched byte, valid two cycles after the request
//   cpu_wr_valid_i/_ready_o          CPU write handshake into the write FIFO
//   cpu_wr_addr_i, cpu_wr_data_i     CPU write address and data
//   cpu_rd_valid_i/_ready_o          CPU read handshake (one read outstanding)
//   cpu_rd_addr_i                    CPU read address
//   cpu_rd_done_o, cpu_rd_data_o     CPU read result pulse and byte
//   mem_addr_o, mem_we_o, mem_re_o   RAM command, one operation per cycle
//   mem_wdata_o, mem_rdata_i         RAM write data, read data (valid cycle after mem_re_o)
module mlbmp_mem_arb #(
    parameter int AW         = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          vid_req_i,
    input  logic [AW-1:0] vid_addr_i,
    output logic          vid_valid_o,
    output logic [7:0]    vid_data_o,
    input  logic          cpu_wr_valid_i,
    output logic          cpu_wr_ready_o,
    input  logic [AW-1:0] cpu_wr_addr_i,
    input  logic [7:0]    cpu_wr_data_i,
    input  logic          cpu_rd_valid_i,
    output logic          cpu_rd_ready_o,
    input  logic [AW-1:0] cpu_rd_addr_i,
    output logic          cpu_rd_done_o,
    output logic [7:0]    cpu_rd_data_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic          mem_re_o,
    output logic [7:0]    mem_wdata_o,
    input  logic [7:0]    mem_rdata_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {R_IDLE, R_DRAIN, R_ISSUE, R_DATA} rd_state_e;
    logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [7:0]    fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q;
    rd_state_e     state_q, state_d;
    logic [AW-1:0] rd_addr_q;
    logic          vid_p1_q, vid_valid_q, rd_done_q;
    logic [7:0]    vid_data_q, rd_data_q;
    logic          push, pop, rd_gnt, fifo_empty;

    assign fifo_empty     = count_q == '0;
    assign cpu_wr_ready_o = count_q < (PW+1)'(FIFO_DEPTH);
    assign cpu_rd_ready_o = state_q == R_IDLE;
    assign push           = cpu_wr_valid_i & cpu_wr_ready_o;
    assign rd_gnt         = !vid_req_i && state_q == R_ISSUE;
    // Buffered writes are frozen while the ordered read is being issued/returned.
    assign pop            = !vid_req_i && !fifo_empty && state_q != R_ISSUE && state_q != R_DATA;

    assign mem_re_o    = rst_ni & (vid_req_i | rd_gnt);
    assign mem_we_o    = rst_ni & pop;
    assign mem_addr_o  = vid_req_i ? vid_addr_i : rd_gnt ? rd_addr_q : pop ? fifo_addr_q[rptr_q] : '0;
    assign mem_wdata_o = pop ? fifo_data_q[rptr_q] : '0;

    assign vid_valid_o   = vid_valid_q;
    assign vid_data_o    = vid_data_q;
    assign cpu_rd_done_o = rd_done_q;
    assign cpu_rd_data_o = rd_data_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            R_IDLE:  state_d = cpu_rd_valid_i ? R_DRAIN : R_IDLE;
            R_DRAIN: state_d = fifo_empty ? R_ISSUE : R_DRAIN;
            R_ISSUE: state_d = rd_gnt ? R_DATA : R_ISSUE;
            R_DATA:  state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= cpu_wr_addr_i;
            fifo_data_q[wptr_q] <= cpu_wr_data_i;
        end
        if (state_q == R_IDLE && cpu_rd_valid_i) rd_addr_q <= cpu_rd_addr_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            state_q     <= R_IDLE;
            vid_p1_q    <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
            rd_done_q   <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            count_q     <= count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            state_q     <= state_d;
            vid_p1_q    <= vid_req_i;
            vid_valid_q <= vid_p1_q;
            if (vid_p1_q) vid_data_q <= mem_rdata_i;
            rd_done_q   <= state_q == R_DATA;
            if (state_q == R_DATA) rd_data_q <= mem_rdata_i;
        end
    end
endmodule
